edge_generator: RTL and testbench



---
 rtl/edge_generator.sv | 134 +++++++++++++
 tb/tb_edge_generator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_generator.sv
// Level generator driven by single-cycle rise/fall requests, with minimum dwell
// times, a one-deep queue for an early opposite request, and error flagging.
// Optional pulse mode: define AUTO_FALL_EN so every accepted rise auto-falls after MIN_HIGH cycles.
module edge_generator #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rise_req,
  input  logic fall_req,
  output logic out,
  output logic ack,
  output logic busy,
  output logic err
);

  localparam logic [1:0] LOW_STABLE  = 2'd0;
  localparam logic [1:0] HIGH_HOLD   = 2'd1;
  localparam logic [1:0] HIGH_STABLE = 2'd2;
  localparam logic [1:0] LOW_HOLD    = 2'd3;

  localparam logic [CNT_W-1:0] HIGH_RELOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_RELOAD  = CNT_W'(MIN_LOW - 1);

`ifdef AUTO_FALL_EN
  localparam bit PULSE_MODE = 1'b1;
`else
  localparam bit PULSE_MODE = 1'b0;
`endif

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pending, pending_n;
  logic             out_n, ack_n, busy_n, err_n;
  logic             want, same, reject;

  // want = request for the opposite level, same = request for the level already driven
  assign want = out ? fall_req : rise_req;
  assign same = out ? rise_req : fall_req;

  // A rejected request freezes the whole cycle (state, counter, queue), which
  // also guarantees ack and err can never coincide.
  always_comb begin
    reject = (rise_req & fall_req) | same | (want & pending);
    if (PULSE_MODE) reject = reject | fall_req;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    out_n     = out;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    if (reject) begin
      err_n = 1'b1;
    end else begin
      case (state)
        LOW_STABLE: begin
          if (rise_req) begin
            out_n   = 1'b1;
            ack_n   = 1'b1;
            state_n = HIGH_HOLD;
            cnt_n   = HIGH_RELOAD;
          end
        end
        HIGH_STABLE: begin
          if (fall_req) begin
            out_n   = 1'b0;
            ack_n   = 1'b1;
            state_n = LOW_HOLD;
            cnt_n   = LOW_RELOAD;
          end
        end
        HIGH_HOLD: begin
          if (cnt == '0) begin
            pending_n = 1'b0;
            if (PULSE_MODE || pending || fall_req) begin
              out_n   = 1'b0;
              ack_n   = 1'b1;
              state_n = LOW_HOLD;
              cnt_n   = LOW_RELOAD;
            end else begin
              state_n = HIGH_STABLE;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
            if (fall_req) pending_n = 1'b1;
          end
        end
        default: begin
          if (cnt == '0) begin
            pending_n = 1'b0;
            if (pending || rise_req) begin
              out_n   = 1'b1;
              ack_n   = 1'b1;
              state_n = HIGH_HOLD;
              cnt_n   = HIGH_RELOAD;
            end else begin
              state_n = LOW_STABLE;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
            if (rise_req) pending_n = 1'b1;
          end
        end
      endcase
    end
    busy_n = (state_n == HIGH_HOLD) || (state_n == LOW_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= LOW_STABLE;
      cnt     <= '0;
      pending <= 1'b0;
      out     <= 1'b0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      out     <= out_n;
      ack     <= ack_n;
      busy    <= busy_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: directed vector table plus randomized requests
// checked against a dwell-age reference model (handles AUTO_FALL_EN builds too).
module tb_edge_generator;

  localparam int MIN_HIGH = 4;
  localparam int MIN_LOW  = 3;

`ifdef AUTO_FALL_EN
  localparam bit PULSE_MODE = 1'b1;
`else
  localparam bit PULSE_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rise_req = 1'b0;
  logic fall_req = 1'b0;
  logic out, ack, busy, err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic rst_n;
    logic rise;
    logic fall;
    logic e_out;
    logic e_ack;
    logic e_busy;
    logic e_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: level, whether a dwell is running, accepted cycles since the last change, queued request
  bit m_out, m_run, m_pend, m_ack, m_err;
  int m_age;

  always #5 clk = ~clk;

  edge_generator #(
    .MIN_HIGH(MIN_HIGH),
    .MIN_LOW (MIN_LOW),
    .CNT_W   (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rise_req(rise_req),
    .fall_req(fall_req),
    .out     (out),
    .ack     (ack),
    .busy    (busy),
    .err     (err)
  );

  function automatic void modelStep(bit r, bit rs, bit fs);
    bit want, same, reject;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      m_out = 1'b0; m_run = 1'b0; m_pend = 1'b0; m_age = 0;
      return;
    end
    want   = m_out ? fs : rs;
    same   = m_out ? rs : fs;
    reject = (rs && fs) || same || (m_run && m_pend && want) || (PULSE_MODE && fs);
    if (reject) begin
      m_err = 1'b1;
      return;
    end
    if (!m_run) begin
      if (want) begin
        m_out = !m_out; m_run = 1'b1; m_age = 0; m_pend = 1'b0; m_ack = 1'b1;
      end
    end else begin
      m_age++;
      if (m_age >= (m_out ? MIN_HIGH : MIN_LOW)) begin
        if (m_pend || want || (PULSE_MODE && m_out)) begin
          m_out = !m_out; m_age = 0; m_pend = 1'b0; m_ack = 1'b1;
        end else begin
          m_run = 1'b0; m_pend = 1'b0;
        end
      end else if (want) begin
        m_pend = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(string name, logic actual, logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(logic r, logic rs, logic fs);
    reset_n  = r;
    rise_req = rs;
    fall_req = fs;
    @(posedge clk);
    #1;
    modelStep(r, rs, fs);
  endtask

  task automatic addVec(logic r, logic rs, logic fs, logic o, logic a, logic b, logic e);
    vec_t v;
    v.rst_n = r; v.rise = rs; v.fall = fs;
    v.e_out = o; v.e_ack = a; v.e_busy = b; v.e_err = e;
    vecs.push_back(v);
  endtask

  initial begin
    m_out = 1'b0; m_run = 1'b0; m_pend = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_age = 0;

    // rst, rise, fall -> out, ack, busy, err (expected after the edge)
    addVec(0,0,0, 0,0,0,0);
    addVec(0,0,0, 0,0,0,0);
    addVec(1,0,0, 0,0,0,0);
`ifndef AUTO_FALL_EN
    addVec(1,0,0, 0,0,0,0);
    addVec(1,1,0, 1,1,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,1, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 0,1,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,0,0);
    addVec(1,1,1, 0,0,0,1);
    addVec(1,0,1, 0,0,0,1);
    addVec(1,1,0, 1,1,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,0,0);
    addVec(1,1,0, 1,0,0,1);
    addVec(1,0,0, 1,0,0,0);
    addVec(1,0,1, 0,1,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,0,0);
    addVec(1,1,0, 1,1,1,0);
    addVec(1,0,1, 1,0,1,0);
    addVec(1,0,1, 1,0,1,1);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 0,1,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,1,0, 0,0,1,0);
    addVec(1,0,0, 1,1,1,0);
    addVec(1,0,1, 1,0,1,0);
    addVec(0,0,0, 0,0,0,0);
    addVec(1,0,0, 0,0,0,0);
    addVec(1,0,0, 0,0,0,0);
    addVec(1,1,0, 1,1,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,1, 0,1,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,1,0, 1,1,1,0);
    addVec(1,0,0, 1,0,1,0);
`else
    addVec(1,1,0, 1,1,1,0);
    addVec(1,0,1, 1,0,1,1);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 1,0,1,0);
    addVec(1,0,0, 0,1,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,1,0);
    addVec(1,0,0, 0,0,0,0);
    addVec(1,0,1, 0,0,0,1);
`endif
    addVec(0,0,0, 0,0,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].rise, vecs[i].fall);
      checkOutput($sformatf("vec%0d out", i),  out,  vecs[i].e_out);
      checkOutput($sformatf("vec%0d ack", i),  ack,  vecs[i].e_ack);
      checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      checkOutput($sformatf("vec%0d err", i),  err,  vecs[i].e_err);
    end

    // Random requests with occasional resets, compared against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      logic r, rs, fs;
      r  = ($urandom_range(99) != 0);
      rs = ($urandom_range(3) == 0);
      fs = ($urandom_range(3) == 0);
      applyStimulus(r, rs, fs);
      checkOutput($sformatf("rnd%0d out", n),  out,  m_out);
      checkOutput($sformatf("rnd%0d ack", n),  ack,  m_ack);
      checkOutput($sformatf("rnd%0d busy", n), busy, m_run);
      checkOutput($sformatf("rnd%0d err", n),  err,  m_err);
      checkOutput($sformatf("rnd%0d ack_and_err", n), ack & err, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
